magnetron_pwm_ctrl: RTL and testbench

//  Sequential magnetron controller: start/pause/resume/clear state machine

---
 rtl/magnetron_pwm_ctrl.sv | 122 ++++++++++++
 tb/tb_magnetron_pwm_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/magnetron_pwm_ctrl.sv
// Magnetron controller: IDLE/RUN/PAUSED cook FSM with interlocks, slot-based
// duty-cycle power control and a minimum-off guard on the drive output.
module magnetron_pwm_ctrl #(
  parameter int LEVELS      = 10,
  parameter int SLOT_CYCLES = 100,
  parameter int MIN_OFF     = 16,
  parameter int LVL_W       = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [LVL_W-1:0] power_level,
  output logic             mag_on,
  output logic [1:0]       state,
  output logic [LVL_W-1:0] active_lvl
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int OFF_W = $clog2(MIN_OFF + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEVELS - 1);
  localparam logic [OFF_W-1:0] OFF_SAT  = OFF_W'(MIN_OFF);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(LEVELS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_BAD    = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
  logic [LVL_W-1:0] active_lvl_q, active_lvl_d;
  logic [OFF_W-1:0] off_cnt_q, off_cnt_d;
  logic             mag_on_q, mag_on_d;

  logic start, kill, abort, guard_ok;

  assign start = !startn;
  assign abort = !clearn || timer_done;
  assign kill  = abort || !door_closed || !stopn;

  // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    slot_idx_d   = slot_idx_q;
    active_lvl_d = active_lvl_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !kill) begin
          state_d      = ST_RUN;
          active_lvl_d = (power_level > LVL_MAX) ? LVL_MAX : power_level;
          slot_cnt_d   = '0;
          slot_idx_d   = '0;
        end
      end
      ST_RUN: begin
        // The cycle spent in RUN is consumed even if this edge leaves RUN.
        if (slot_cnt_q == LAST_CNT) begin
          slot_cnt_d = '0;
          slot_idx_d = (slot_idx_q == LAST_IDX) ? '0 : slot_idx_q + 1'b1;
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!door_closed || !stopn) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start && !kill) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The guard only blocks a rising edge; an output already on stays on.
  always_comb begin
    off_cnt_d = mag_on_q ? '0 : ((off_cnt_q == OFF_SAT) ? off_cnt_q : off_cnt_q + 1'b1);
    guard_ok  = mag_on_q || (off_cnt_d >= OFF_SAT);
    mag_on_d  = (state_d == ST_RUN) && (LVL_W'(slot_idx_d) < active_lvl_d) && guard_ok;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      slot_cnt_q   <= '0;
      slot_idx_q   <= '0;
      active_lvl_q <= '0;
      off_cnt_q    <= OFF_SAT;
      mag_on_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      slot_idx_q   <= slot_idx_d;
      active_lvl_q <= active_lvl_d;
      off_cnt_q    <= off_cnt_d;
      mag_on_q     <= mag_on_d;
    end
  end

  assign mag_on     = mag_on_q;
  assign state      = state_q;
  assign active_lvl = active_lvl_q;

endmodule

// File: tb/tb_magnetron_pwm_ctrl.sv
// Bench for magnetron_pwm_ctrl: directed scenarios with literal expectations,
// then randomized stimulus checked every cycle against a time-based model.
module tb_magnetron_pwm_ctrl;

  localparam int L  = 4;
  localparam int S  = 3;
  localparam int MO = 2;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
  logic          door_closed = 1'b1, timer_done = 1'b0;
  logic [LW-1:0] power_level = '0;
  logic          mag_on;
  logic [1:0]    state;
  logic [LW-1:0] active_lvl;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  magnetron_pwm_ctrl #(.LEVELS(L), .SLOT_CYCLES(S), .MIN_OFF(MO), .LVL_W(LW)) dut (
    .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .timer_done(timer_done), .power_level(power_level),
    .mag_on(mag_on), .state(state), .active_lvl(active_lvl)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Model: cook progress is a single position in the duty period; the guard
  // is the length of the current run of zero output cycles.
  int m_state = 0, m_pos = 0, m_lvl = 0, m_zero = 1000;
  bit m_mag = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_state = 0; m_pos = 0; m_lvl = 0; m_zero = 1000; m_mag = 1'b0;
    end else begin
      int  nxt;
      bit  go, want;
      go  = !startn && door_closed && !timer_done && clearn && stopn;
      nxt = m_state;
      if (m_state == 0) begin
        if (go) nxt = 1;
      end else if (m_state == 1) begin
        if (!clearn || timer_done) nxt = 0;
        else if (!door_closed || !stopn) nxt = 2;
      end else begin
        if (!clearn || timer_done) nxt = 0;
        else if (go) nxt = 1;
      end
      if (m_state == 1) m_pos = (m_pos + 1) % (L * S);
      if (m_state == 0 && nxt == 1) begin
        m_pos = 0;
        m_lvl = (power_level > L) ? L : int'(power_level);
      end
      m_zero = m_mag ? 0 : ((m_zero < 1000) ? m_zero + 1 : m_zero);
      want   = (nxt == 1) && ((m_pos / S) < m_lvl);
      m_mag  = want && (m_mag || m_zero >= MO);
      m_state = nxt;
    end
  end

  always @(negedge clk) begin
    check("state_vs_model", state, m_state);
    check("mag_on_vs_model", mag_on, m_mag);
    check("active_lvl_vs_model", active_lvl, m_lvl);
  end

  task automatic start_pulse();
    startn = 1'b0; cyc(1); startn = 1'b1;
  endtask

  task automatic clear_pulse();
    clearn = 1'b0; cyc(1); clearn = 1'b1;
  endtask

  initial begin
    int n, ones, zeros;
    bit rose;
    #1 resetn = 1'b0;
    cyc(2);
    check("reset_state", state, 0);
    check("reset_mag_on", mag_on, 0);
    check("reset_active_lvl", active_lvl, 0);
    resetn = 1'b1;
    cyc(1);

    // Basic cook at level 2: 6 on, 6 off, then on again.
    power_level = 2;
    start_pulse();
    check("basic_state_run", state, 1);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("basic_pattern_%0d", i), mag_on, (i < 6) ? 1 : 0);
      cyc(1);
    end
    check("basic_rerise", mag_on, 1);

    // Door open pauses at once; resume continues from the held position.
    door_closed = 1'b0;
    cyc(1);
    check("door_state_paused", state, 2);
    check("door_mag_off", mag_on, 0);
    cyc(2);
    door_closed = 1'b1;
    start_pulse();
    check("resume_state_run", state, 1);
    n = 0;
    while (mag_on && n < 20) begin n++; cyc(1); end
    check("resume_on_cycles", n, 5);

    // Clear while paused keeps the latched level.
    stopn = 1'b0; cyc(1); stopn = 1'b1;
    check("stop_state_paused", state, 2);
    clear_pulse();
    check("clear_state_idle", state, 0);
    check("clear_keeps_lvl", active_lvl, 2);

    // Full power: continuous on.
    power_level = 4;
    start_pulse();
    check("full_active_lvl", active_lvl, 4);
    ones = 0;
    for (int i = 0; i < 16; i++) begin ones += int'(mag_on); cyc(1); end
    check("full_continuous_on", ones, 16);

    // Guard: stop then immediate restart.
    stopn = 1'b0; cyc(1); stopn = 1'b1;
    check("guard_stop_off", mag_on, 0);
    startn = 1'b0;
    zeros = 1; rose = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (mag_on) begin rose = 1'b1; break; end
      zeros++;
    end
    startn = 1'b1;
    check("guard_rose", rose, 1);
    check("guard_min_gap", zeros >= MO, 1);

    // Level 0: RUN but never on.
    clear_pulse();
    power_level = 0;
    start_pulse();
    check("lvl0_state_run", state, 1);
    ones = 0;
    for (int i = 0; i < 12; i++) begin ones += int'(mag_on); cyc(1); end
    check("lvl0_never_on", ones, 0);

    // Level above LEVELS clamps.
    clear_pulse();
    power_level = 9;
    start_pulse();
    check("lvl9_clamped", active_lvl, 4);

    // timer_done blocks start.
    clear_pulse();
    timer_done = 1'b1; startn = 1'b0;
    cyc(3);
    check("timer_done_idle", state, 0);
    timer_done = 1'b0; startn = 1'b1;

    // Async reset mid-cook.
    start_pulse();
    cyc(2);
    check("pre_reset_on", mag_on, 1);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_mag_off", mag_on, 0);
    check("async_reset_idle", state, 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(2);
    check("post_reset_idle", state, 0);

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      startn      = ($urandom_range(0, 99) < 30) ? 1'b0 : 1'b1;
      stopn       = ($urandom_range(0, 99) < 2)  ? 1'b0 : 1'b1;
      clearn      = ($urandom_range(0, 99) < 1)  ? 1'b0 : 1'b1;
      door_closed = ($urandom_range(0, 99) < 2)  ? 1'b0 : 1'b1;
      timer_done  = ($urandom_range(0, 99) < 1)  ? 1'b1 : 1'b0;
      power_level = LW'($urandom_range(0, 9));
      if ($urandom_range(0, 499) == 0) begin
        #2 resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
      end
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
